data_mem_obi: RTL and testbench
===============================

Name: data_mem_obi

Overview:
- Parametrised data-memory slave for the core's data interface (req/gnt/rvalid handshake). Successor to the fixed-latency data RAM model.
- Adds configurable grant wait-states, configurable response latency, an outstanding-transaction limit, address-range error reporting and byte-enable writes.
- Sits between the core's data port and the system bus in the simulation top and in FPGA bring-up builds.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be 32 or 64; BE width = DATA_W/8.
- DEPTH_WORDS, 1024, memory depth in DATA_W words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- GNT_DELAY, 0, cycles req must be held before gnt; 0 means same-cycle grant.
- RD_LATENCY, 1, cycles from grant edge to rvalid; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum granted transactions without rvalid; legal range 1..RD_LATENCY+1.
- LFSR_SEED, 16'hACE1, seed for the optional stall generator.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- data_req_i  in  1  request; address/we/be/wdata stable while req=1 and gnt=0.
- data_gnt_o  out  1  grant; transaction accepted on the clk edge where req&gnt.
- data_rvalid_o  out  1  one-cycle response strobe; one per granted transaction, in order.
- data_we_i  in  1  1=write, 0=read.
- data_be_i  in  DATA_W/8  byte enables; applied on writes only.
- data_addr_i  in  ADDR_W  byte address.
- data_wdata_i  in  DATA_W  write data.
- data_rdata_o  out  DATA_W  read data, valid with rvalid.
- data_err_o  out  1  error, valid with rvalid.

Behaviour:
- Reset (async, rst_ni=0): gnt, rvalid, err = 0; rdata = 0; FSM = IDLE; wait counter, outstanding counter and response pipeline cleared.
  - Memory array is not cleared.
  - A transaction granted before reset produces no response.
- Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - Address is out of range if addr < BASE_ADDR or index >= DEPTH_WORDS.
  - Low address bits are ignored; no misalignment error.
- can_accept = (outstanding < MAX_OUTSTANDING) | rvalid retiring this cycle.
- Grant FSM:
  - IDLE: if req & can_accept & GNT_DELAY==0, gnt=1 combinationally and the FSM stays in IDLE. Else if req, go to WAIT with cnt=0.
  - WAIT: cnt increments each cycle while req=1. When cnt==GNT_DELAY-1, go to READY. If req drops, return to IDLE (protocol violation; the transaction is discarded).
  - READY: gnt = req & can_accept. Stay in READY until granted, then go to IDLE. Every new request pays the full GNT_DELAY again.
- On the grant edge:
  - Write, in range: bytes with be=1 are updated. be=0 leaves memory unchanged.
  - Read, in range: the full word is sampled.
  - Out of range: no memory access; err=1 and rdata=0 in the response.
- Response pipeline: shift register of depth RD_LATENCY carrying {valid, err, rdata}.
  - rvalid asserts exactly RD_LATENCY cycles after the grant edge.
  - Writes also return rvalid, with rdata=0.
  - Outstanding: +1 on grant, -1 on rvalid; both in the same cycle leaves it unchanged. Never exceeds MAX_OUTSTANDING.
- Read-after-write ordering: a read granted on any later cycle returns the written data.
- rdata, err and rvalid are zero when no response is due.

Optional Feature:
- Macro: DATA_MEM_RANDSTALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, advances every cycle.
  - gnt is additionally masked while lfsr[0]==1, producing a pseudo-random grant stall.
  - The response latency is unaffected.
- Undefined: no LFSR logic; grant timing is purely GNT_DELAY/outstanding driven.

Test Plan:
- Defaults. Write addr 0x10, wdata 0xDEADBEEF, be=4'hF; then read 0x10. Required: gnt in the same cycle as req; rvalid 1 cycle after each grant; read rdata=0xDEADBEEF, err=0.
- Byte enables. Over 0xDEADBEEF, write addr 0x10, wdata 0x00000011, be=4'b0001; then write 0x00220000, be=4'b0100. Required: a read returns 0xDE22BE11.
- GNT_DELAY=3. Hold req from cycle 0. Required: gnt at cycle 3. With RD_LATENCY=4, rvalid at cycle 7.
- RD_LATENCY=3, MAX_OUTSTANDING=2. Issue reads on consecutive cycles. Required: grants on cycles 0 and 1, no grant on cycle 2, grant on cycle 3 (coincides with the first rvalid); responses in order.
- Range error. DEPTH_WORDS=1024, read addr 0x1000 and write 0x2000. Required: rvalid with err=1 and rdata=0; a subsequent read of 0x0 shows memory unchanged.
- Reset mid-operation. Deassert rst_ni between grant and rvalid with RD_LATENCY=3. Required: no rvalid after reset release; outstanding=0; previously written memory is retained.

Source files
------------

// File: rtl/data_mem_obi.sv
// Data-memory slave on a req/gnt/rvalid port: grant wait-states, fixed response latency,
// outstanding limit, range errors, byte-enable writes. DATA_MEM_RANDSTALL_EN adds LFSR grant stalls.
module data_mem_obi #(
   parameter int                ADDR_W          = 32,
   parameter int                DATA_W          = 32,
   parameter int                DEPTH_WORDS     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR       = 32'h0000_0000,
   parameter int                GNT_DELAY       = 0,
   parameter int                RD_LATENCY      = 1,
   parameter int                MAX_OUTSTANDING = 2,
   parameter logic [15:0]       LFSR_SEED       = 16'hACE1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                data_req_i,
   output logic                data_gnt_o,
   output logic                data_rvalid_o,
   input  logic                data_we_i,
   input  logic [DATA_W/8-1:0] data_be_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_err_o
);

   localparam int BE_W     = DATA_W / 8;
   localparam int OFF_BITS = $clog2(BE_W);
   localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam int WCNT_W   = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t                         state;
   logic [WCNT_W-1:0]              wait_cnt;
   logic [CNT_W-1:0]               out_cnt;
   logic [RD_LATENCY-1:0]          vld_pipe;
   logic [RD_LATENCY-1:0]          err_pipe;
   logic [RD_LATENCY-1:0][DATA_W-1:0] dat_pipe;
   logic [DATA_W-1:0]              mem [DEPTH_WORDS];

   logic [ADDR_W:0] idx;
   logic            in_range;
   logic            can_accept;
   logic            gnt_state;
   logic            stall;
   logic            fire;

   // One extra bit keeps the borrow of addr < BASE_ADDR, which lands the index far above DEPTH_WORDS.
   assign idx      = ({1'b0, data_addr_i} - {1'b0, BASE_ADDR}) >> OFF_BITS;
   assign in_range = idx < (ADDR_W+1)'(DEPTH_WORDS);

   assign can_accept = (out_cnt < CNT_W'(MAX_OUTSTANDING)) | data_rvalid_o;
   assign gnt_state  = (state == READY) | ((state == IDLE) & (GNT_DELAY == 0));
   assign data_gnt_o = rst_ni & data_req_i & can_accept & ~stall & gnt_state;
   assign fire       = data_gnt_o;

`ifdef DATA_MEM_RANDSTALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr <= LFSR_SEED;
      else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = lfsr[0];
`else
   // Seed is only consumed by the stall generator.
   assign stall = 1'b0 & (^LFSR_SEED);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (data_req_i && GNT_DELAY != 0) begin
                  state    <= (GNT_DELAY == 1) ? READY : WAIT;
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (!data_req_i) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == WCNT_W'(GNT_DELAY - 2)) state <= READY;
               end
            end
            READY: begin
               // A dropped request forfeits the wait so the next one pays the full delay.
               if (fire || !data_req_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_cnt <= '0;
      end else begin
         case ({fire, data_rvalid_o})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= out_cnt - 1'b1;
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= fire;
         err_pipe[0] <= fire & ~in_range;
         dat_pipe[0] <= (fire && !data_we_i && in_range) ? mem[idx[IDX_W-1:0]] : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   // Storage survives reset.
   always_ff @(posedge clk_i) begin
      if (fire && data_we_i && in_range) begin
         for (int b = 0; b < BE_W; b++) begin
            if (data_be_i[b]) mem[idx[IDX_W-1:0]][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
         end
      end
   end

   assign data_rvalid_o = vld_pipe[RD_LATENCY-1];
   assign data_err_o    = err_pipe[RD_LATENCY-1];
   assign data_rdata_o  = dat_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_data_mem_obi.sv
// Bench for data_mem_obi: three configurations driven one at a time against a
// transaction-level model (word array plus a queue of due responses).
module tb_data_mem_obi;

   logic        clk;
   logic        rst_n;
   logic        req   [3];
   logic        we    [3];
   logic [3:0]  be    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic        gnt   [3];
   logic        rvalid[3];
   logic        err   [3];
   logic [31:0] rdata [3];

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] mdl [3][16];
   int          cyc, hold, rv_cyc, g_cyc;
   logic [31:0] last_rd;
   logic        last_gnt;
   int          n_vec, n_err;

   data_mem_obi u_a (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
      .data_rvalid_o(rvalid[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]),
      .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

   data_mem_obi #(.GNT_DELAY(3), .RD_LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
      .data_rvalid_o(rvalid[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]),
      .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

   data_mem_obi #(.RD_LATENCY(3), .MAX_OUTSTANDING(2)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
      .data_rvalid_o(rvalid[2]), .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]),
      .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lat(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 3;
   endfunction

   function automatic int dly(input int k);
      return (k == 1) ? 3 : 0;
   endfunction

   function automatic int mx(input int k);
      return (k >= 0) ? 2 : 2;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of instance k: drive, check gnt and response at the falling edge, update model.
   task automatic step(input int k, input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, output bit g);
      resp_t e;
      bit    ret, in;
      int    ix;
      req[k] = r; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
      @(negedge clk);
      ret = (sb.size() != 0) && (sb[0].due == cyc);
      g   = r && (hold >= dly(k)) && ((sb.size() < mx(k)) || ret);
      last_gnt = gnt[k];
      chk("gnt", 64'(gnt[k]), 64'(g));
      if (rvalid[k]) begin
         rv_cyc  = cyc;
         last_rd = rdata[k];
      end
      if (ret) begin
         chk("resp", {rvalid[k], err[k], rdata[k]}, {1'b1, sb[0].err, sb[0].data});
         void'(sb.pop_front());
      end else begin
         chk("no_resp", {rvalid[k], err[k], rdata[k]}, 34'd0);
      end
      if (g) begin
         in     = a < 32'h1000;
         ix     = int'(a >> 2) & 15;
         e.due  = cyc + lat(k);
         e.err  = !in;
         e.data = (in && !w) ? mdl[k][ix] : 32'd0;
         if (in && w)
            for (int i = 0; i < 4; i++) if (b[i]) mdl[k][ix][8*i +: 8] = d[8*i +: 8];
         sb.push_back(e);
         hold  = 0;
         g_cyc = cyc;
      end else if (r) hold++;
      else hold = 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic txn(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output int waited);
      bit g;
      int n;
      g = 1'b0;
      n = 0;
      while (!g && n < 40) begin
         step(k, 1'b1, w, b, a, d, g);
         n++;
      end
      waited = n - 1;
   endtask

   task automatic idle(input int k, input int n);
      bit g;
      for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, g);
   endtask

   task automatic prewrite(input int k);
      int w;
      for (int i = 0; i < 16; i++) txn(k, 1'b1, 4'hF, 32'(i * 4), $urandom(), w);
      idle(k, lat(k) + 1);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom();
      return ($urandom_range(0, 7) == 0) ? (a | 32'h1000) : (a & 32'h3F);
   endfunction

   initial begin
      int         w;
      bit         g;
      logic [3:0] gb;
      n_vec = 0; n_err = 0; cyc = 0; hold = 0; rv_cyc = -1; g_cyc = 0;
      last_rd = '0; last_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; be[k] = '0; addr[k] = '0; wdata[k] = '0;
      end
      rst_n  = 1'b0;
      req[0] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_gnt", 64'(gnt[k]), 64'd0);
         chk("rst_resp", {rvalid[k], err[k], rdata[k]}, 34'd0);
      end
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      rst_n  = 1'b1;

      // Defaults: same-cycle grant, one-cycle response.
      prewrite(0);
      txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, w);
      txn(0, 1'b0, 4'hF, 32'h10, 32'h0, w);
      chk("a_gnt_wait", 64'(w), 64'd0);
      idle(0, 1);
      chk("a_rd_lat", 64'(rv_cyc - g_cyc), 64'd1);
      chk("a_rd_data", 64'(last_rd), 64'hDEADBEEF);
      txn(0, 1'b1, 4'b0001, 32'h10, 32'h00000011, w);
      txn(0, 1'b1, 4'b0100, 32'h10, 32'h00220000, w);
      txn(0, 1'b0, 4'h0,    32'h10, 32'h0, w);
      idle(0, 1);
      chk("a_be_merge", 64'(last_rd), 64'hDE22BE11);
      txn(0, 1'b0, 4'hF, 32'h1000, 32'h0, w);
      txn(0, 1'b1, 4'hF, 32'h2000, $urandom(), w);
      txn(0, 1'b0, 4'hF, 32'h0, 32'h0, w);
      idle(0, 2);
      repeat (150) step(0, $urandom_range(0, 3) != 0, 1'($urandom()), 4'($urandom()),
                        rnd_addr(), $urandom(), g);
      idle(0, 2);

      // GNT_DELAY=3, RD_LATENCY=4.
      prewrite(1);
      w = cyc;
      rv_cyc = -1;
      g_cyc = w;
      txn(1, 1'b1, 4'hF, 32'h8, 32'h12345678, w);
      chk("b_gnt_wait", 64'(w), 64'd3);
      w = g_cyc - 3;
      idle(1, 6);
      chk("b_rvalid_cyc", 64'(rv_cyc - w), 64'd7);
      step(1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, g);
      step(1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, g);
      idle(1, 1);
      txn(1, 1'b0, 4'hF, 32'h8, 32'h0, w);
      chk("b_regrant_wait", 64'(w), 64'd3);
      idle(1, 5);
      chk("b_rd_data", 64'(last_rd), 64'h12345678);
      repeat (20) begin
         txn(1, 1'(($urandom())), 4'($urandom()), rnd_addr(), $urandom(), w);
         idle(1, $urandom_range(0, 2));
      end
      idle(1, 5);

      // RD_LATENCY=3, MAX_OUTSTANDING=2: outstanding limit.
      prewrite(2);
      w = 0;
      for (int c = 0; c < 12; c++) begin
         step(2, 1'b1, 1'b0, 4'hF, 32'(w * 4), 32'h0, g);
         if (c < 4) gb[c] = last_gnt;
         if (g) w = (w + 1) & 15;
      end
      chk("c_burst_gnt", 64'(gb), 64'b1011);
      idle(2, 4);
      repeat (30) begin
         txn(2, 1'($urandom()), 4'($urandom()), rnd_addr(), $urandom(), w);
         idle(2, $urandom_range(0, 1));
      end
      idle(2, 4);

      // Reset between grant and rvalid.
      txn(2, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D, w);
      txn(2, 1'b0, 4'hF, 32'h4, 32'h0, w);
      req[2] = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      chk("c_rst_resp", {rvalid[2], err[2], rdata[2]}, 34'd0);
      sb.delete();
      hold = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      idle(2, 5);
      step(2, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, g);
      gb[0] = last_gnt;
      step(2, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, g);
      gb[1] = last_gnt;
      step(2, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, g);
      gb[2] = last_gnt;
      chk("c_post_rst_gnt", 64'(gb[2:0]), 64'b011);
      txn(2, 1'b0, 4'hF, 32'h4, 32'h0, w);
      idle(2, 4);
      chk("c_mem_kept", 64'(last_rd), 64'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
